// File: rtl/bcd_multi_cnt.sv
// Multi-digit BCD up/down counter with programmable inclusive bounds.
// Supports wrap or saturate at the bounds, parallel load with BCD validation,
// a combinational terminal-count flag for chaining, and registered pulses
// for wrap events and rejected loads.
module bcd_multi_cnt #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   min_val,
  input  logic [4*DIGITS-1:0]   max_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  wrap,
  output logic                  err,
  output logic                  cfg_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic         at_max, at_min;

  // Every nibble must be a decimal digit.
  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // BCD increment: a 9 rolls to 0 and carries into the next digit.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement: a 0 rolls to 9 and borrows from the next digit.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Bound checks and terminal count; for valid BCD a plain binary compare
  // orders values the same way as a decimal compare.
  always_comb begin
    cfg_err = !is_bcd(min_val) || !is_bcd(max_val) || (min_val > max_val);
    at_max  = (cnt_q >= max_val);
    at_min  = (cnt_q <= min_val);
    tc      = !cfg_err && ((dir && at_max) || (!dir && at_min));
  end

  // Next-state selection: load, then config hold, then count, else hold.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (is_bcd(load_val)) cnt_d = load_val;
      else                  err_d = 1'b1;
    end else if (cfg_err) begin
      cnt_d = cnt_q;
    end else if (en) begin
      if (dir) begin
        if (!at_max) begin
          cnt_d = bcd_inc(cnt_q);
        end else if (!mode) begin
          cnt_d  = min_val;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          cnt_d = bcd_dec(cnt_q);
        end else if (!mode) begin
          cnt_d  = max_val;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
